// File: rtl/mdu_issue_ctrl.sv
// Issue and hazard controller for the HI/LO multiply/divide unit.
// Decodes the EX-stage SPECIAL funct for the mul/div and HI/LO move ops and
// drives the unit's start, select and write strobes. A down-counter tracks
// operation latency, and a watchdog catches a unit that never raises its flag.
//
// Handshake: an EX-stage op is taken when CTL_Valid=1, its funct is decoded,
// CTL_Flush=0 and CTL_Stall=0. CTL_Stall holds the pipeline until the op
// can be taken. MUL_Start and MUL_Write are one-cycle registered pulses
// that the unit samples without back-pressure.
//
// Completion timing: the counter is loaded with the latency on entry to RUN.
// The op retires on the edge where the counter expires (value 1 or 0) while
// MUL_Flag is high. CTL_Busy is therefore high for 1 + latency cycles when
// the unit flags on time. If the counter sits at 0 without MUL_Flag for
// WDOG_CYCLES cycles, CTL_Error is set and the FSM returns to IDLE.
module mdu_issue_ctrl #(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 2,
  parameter int WDOG_CYCLES = 63
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       CTL_Valid,
  input  logic [5:0] CTL_Funct,
  input  logic       CTL_Flush,
  input  logic       MUL_Flag,
  output logic       MUL_Start,
  output logic [1:0] MUL_SelMD,
  output logic       MUL_SelHL,
  output logic       MUL_Write,
  output logic       CTL_Stall,
  output logic       CTL_Busy,
  output logic       CTL_Error
);

  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
  localparam logic [3:0] MUL_LAT = 4'(MUL_LATENCY);
  localparam logic [3:0] DIV_LAT = 4'(DIV_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      lat_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            wr_sel_hi;

  logic is_muldiv;
  logic is_hilo;
  logic is_mt;
  logic is_mf;
  logic op_valid;
  logic accept;

  // Funct decode: 0x18-0x1B are mul/div, 0x10-0x13 are the HI/LO moves.
  // Within each group bit0 marks MTxx / unsigned and bit1 marks LO / divide.
  always_comb begin
    is_muldiv = (CTL_Funct[5:2] == 4'b0110);
    is_hilo   = (CTL_Funct[5:2] == 4'b0100);
    is_mt     = is_hilo & CTL_Funct[0];
    is_mf     = is_hilo & ~CTL_Funct[0];
    op_valid  = CTL_Valid & ~CTL_Flush & (is_muldiv | is_hilo);
  end

  // Hazard stall: any decoded op waits while an operation is in flight or
  // while a HI/LO write strobe owns the select line this cycle.
  always_comb begin
    CTL_Stall = op_valid & ((state != ST_IDLE) | MUL_Write);
    accept    = op_valid & ~CTL_Stall;
  end

  // HI/LO select: the registered write target takes priority, otherwise an
  // MFHI/MFLO that is being taken picks the read source this same cycle.
  always_comb begin
    if (MUL_Write) begin
      MUL_SelHL = wr_sel_hi;
    end else begin
      MUL_SelHL = accept & is_mf & ~CTL_Funct[1];
    end
  end

  assign CTL_Busy = (state != ST_IDLE);

  // Issue FSM, latency counter, watchdog and registered strobes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      lat_cnt   <= 4'd0;
      wd_cnt    <= '0;
      wr_sel_hi <= 1'b0;
      MUL_Start <= 1'b0;
      MUL_Write <= 1'b0;
      MUL_SelMD <= 2'b00;
      CTL_Error <= 1'b0;
    end else begin
      MUL_Start <= 1'b0;
      MUL_Write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && is_muldiv) begin
            state     <= ST_ISSUE;
            MUL_Start <= 1'b1;
            // SelMD bit0 = divide, bit1 = unsigned.
            MUL_SelMD <= {CTL_Funct[0], CTL_Funct[1]};
          end else if (accept && is_mt) begin
            MUL_Write <= 1'b1;
            wr_sel_hi <= ~CTL_Funct[1];
          end
        end
        ST_ISSUE: begin
          state   <= ST_RUN;
          lat_cnt <= MUL_SelMD[0] ? DIV_LAT : MUL_LAT;
          wd_cnt  <= '0;
        end
        ST_RUN: begin
          if ((lat_cnt <= 4'd1) && MUL_Flag) begin
            state   <= ST_IDLE;
            lat_cnt <= 4'd0;
          end else if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else if (wd_cnt == WD_LAST) begin
            CTL_Error <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with default parameters
// (MUL_LATENCY=2, DIV_LATENCY=2, WDOG_CYCLES=63).
// Each table row is one clock cycle: inputs are driven at the falling edge
// and every output is compared 1 ns later against the hand-computed value.
module tb_mdu_issue_ctrl;

  logic       Clk;
  logic       Reset;
  logic       CTL_Valid;
  logic [5:0] CTL_Funct;
  logic       CTL_Flush;
  logic       MUL_Flag;
  logic       MUL_Start;
  logic [1:0] MUL_SelMD;
  logic       MUL_SelHL;
  logic       MUL_Write;
  logic       CTL_Stall;
  logic       CTL_Busy;
  logic       CTL_Error;

  int n_checks = 0;
  int n_errors = 0;

  mdu_issue_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .CTL_Valid (CTL_Valid),
    .CTL_Funct (CTL_Funct),
    .CTL_Flush (CTL_Flush),
    .MUL_Flag  (MUL_Flag),
    .MUL_Start (MUL_Start),
    .MUL_SelMD (MUL_SelMD),
    .MUL_SelHL (MUL_SelHL),
    .MUL_Write (MUL_Write),
    .CTL_Stall (CTL_Stall),
    .CTL_Busy  (CTL_Busy),
    .CTL_Error (CTL_Error)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [5:0] funct;
    logic       flush;
    logic       flag;
    logic       e_start;
    logic [1:0] e_selmd;
    logic       e_selhl;
    logic       e_write;
    logic       e_stall;
    logic       e_busy;
    logic       e_error;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic valid, input logic [5:0] funct,
                     input logic flush, input logic flag,
                     input logic e_start, input logic [1:0] e_selmd,
                     input logic e_selhl, input logic e_write,
                     input logic e_stall, input logic e_busy, input logic e_error);
    vec_t v;
    v.rst = rst; v.valid = valid; v.funct = funct; v.flush = flush; v.flag = flag;
    v.e_start = e_start; v.e_selmd = e_selmd; v.e_selhl = e_selhl;
    v.e_write = e_write; v.e_stall = e_stall; v.e_busy = e_busy; v.e_error = e_error;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act,
                     input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs at the falling edge.
  task automatic drive(input logic rst, input logic valid, input logic [5:0] funct,
                       input logic flush, input logic flag);
    @(negedge Clk);
    Reset     = rst;
    CTL_Valid = valid;
    CTL_Funct = funct;
    CTL_Flush = flush;
    MUL_Flag  = flag;
    #1;
  endtask

  task automatic check_row(input int idx, input vec_t v);
    chk("start", idx, {3'b0, MUL_Start}, {3'b0, v.e_start});
    chk("selmd", idx, {2'b0, MUL_SelMD}, {2'b0, v.e_selmd});
    chk("selhl", idx, {3'b0, MUL_SelHL}, {3'b0, v.e_selhl});
    chk("write", idx, {3'b0, MUL_Write}, {3'b0, v.e_write});
    chk("stall", idx, {3'b0, CTL_Stall}, {3'b0, v.e_stall});
    chk("busy",  idx, {3'b0, CTL_Busy},  {3'b0, v.e_busy});
    chk("error", idx, {3'b0, CTL_Error}, {3'b0, v.e_error});
  endtask

  initial begin
    Reset = 1'b1; CTL_Valid = 1'b0; CTL_Funct = 6'h00; CTL_Flush = 1'b0; MUL_Flag = 1'b0;

    //    rst v  funct flu flg | st  selmd hl  wr  stl bsy err
    // reset held two cycles
    add(1, 0, 6'h00, 0, 0,    0, 2'b00, 0, 0, 0, 0, 0);
    add(1, 1, 6'h18, 0, 1,    0, 2'b00, 0, 0, 0, 0, 0);
    // MULT, flag high: busy for 1+2 cycles
    add(0, 1, 6'h18, 0, 1,    0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 0, 6'h00, 0, 1,    1, 2'b00, 0, 0, 0, 1, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b00, 0, 0, 0, 1, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b00, 0, 0, 0, 1, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b00, 0, 0, 0, 0, 0);
    // DIVU then MFLO: stalled until busy falls, then reads LO; MFHI reads HI
    add(0, 1, 6'h1B, 0, 1,    0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 1, 6'h12, 0, 1,    1, 2'b11, 0, 0, 1, 1, 0);
    add(0, 1, 6'h12, 0, 1,    0, 2'b11, 0, 0, 1, 1, 0);
    add(0, 1, 6'h12, 0, 1,    0, 2'b11, 0, 0, 1, 1, 0);
    add(0, 1, 6'h12, 0, 1,    0, 2'b11, 0, 0, 0, 0, 0);
    add(0, 1, 6'h10, 0, 1,    0, 2'b11, 1, 0, 0, 0, 0);
    // MTHI in IDLE: one write strobe to HI, no start
    add(0, 1, 6'h11, 0, 1,    0, 2'b11, 0, 0, 0, 0, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b11, 1, 1, 0, 0, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b11, 0, 0, 0, 0, 0);
    // MTLO then MFHI: write select wins, MFHI stalls one cycle
    add(0, 1, 6'h13, 0, 1,    0, 2'b11, 0, 0, 0, 0, 0);
    add(0, 1, 6'h10, 0, 1,    0, 2'b11, 0, 1, 1, 0, 0);
    add(0, 1, 6'h10, 0, 1,    0, 2'b11, 1, 0, 0, 0, 0);
    // MULT then MTLO: stalled until IDLE, then writes LO
    add(0, 1, 6'h18, 0, 1,    0, 2'b11, 0, 0, 0, 0, 0);
    add(0, 1, 6'h13, 0, 1,    1, 2'b00, 0, 0, 1, 1, 0);
    add(0, 1, 6'h13, 0, 1,    0, 2'b00, 0, 0, 1, 1, 0);
    add(0, 1, 6'h13, 0, 1,    0, 2'b00, 0, 0, 1, 1, 0);
    add(0, 1, 6'h13, 0, 1,    0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b00, 0, 1, 0, 0, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b00, 0, 0, 0, 0, 0);
    // MULT with flush: nothing issued
    add(0, 1, 6'h18, 1, 1,    0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b00, 0, 0, 0, 0, 0);
    // DIV, flushed MFLO during ISSUE/RUN: no stall, op completes on time
    add(0, 1, 6'h1A, 0, 1,    0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 1, 6'h12, 1, 1,    1, 2'b01, 0, 0, 0, 1, 0);
    add(0, 1, 6'h12, 1, 1,    0, 2'b01, 0, 0, 0, 1, 0);
    add(0, 1, 6'h12, 1, 1,    0, 2'b01, 0, 0, 0, 1, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b01, 0, 0, 0, 0, 0);
    // MULTU, unrelated funct while busy does not stall
    add(0, 1, 6'h19, 0, 1,    0, 2'b01, 0, 0, 0, 0, 0);
    add(0, 1, 6'h20, 0, 1,    1, 2'b10, 0, 0, 0, 1, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b10, 0, 0, 0, 1, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b10, 0, 0, 0, 1, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b10, 0, 0, 0, 0, 0);
    // MULT, reset while counter=1, new MULT accepted right after
    add(0, 1, 6'h18, 0, 0,    0, 2'b10, 0, 0, 0, 0, 0);
    add(0, 0, 6'h00, 0, 0,    1, 2'b00, 0, 0, 0, 1, 0);
    add(0, 0, 6'h00, 0, 0,    0, 2'b00, 0, 0, 0, 1, 0);
    add(1, 0, 6'h00, 0, 0,    0, 2'b00, 0, 0, 0, 1, 0);
    add(0, 1, 6'h18, 0, 1,    0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 0, 6'h00, 0, 1,    1, 2'b00, 0, 0, 0, 1, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b00, 0, 0, 0, 1, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b00, 0, 0, 0, 1, 0);
    add(0, 0, 6'h00, 0, 1,    0, 2'b00, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].funct, vecs[i].flush, vecs[i].flag);
      check_row(i, vecs[i]);
    end

    // Watchdog: MULT accepted at edge A with the flag held low. The counter
    // reaches 0 at edge A+3, so the error appears at edge A+66, i.e. in
    // observed cycle k=67 counted from the first cycle after A.
    drive(0, 1, 6'h18, 0, 0);
    for (int k = 1; k <= 70; k++) begin
      drive(0, 0, 6'h00, 0, 0);
      chk("wdog_error", 1000 + k, {3'b0, CTL_Error}, {3'b0, (k >= 67)});
      chk("wdog_busy",  1000 + k, {3'b0, CTL_Busy},  {3'b0, (k <= 66)});
    end

    // Error is sticky across a normal operation.
    drive(0, 1, 6'h18, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 6'h00, 0, 1);
      chk("sticky_error", 2000 + k, {3'b0, CTL_Error}, 4'h1);
      chk("sticky_busy",  2000 + k, {3'b0, CTL_Busy},  {3'b0, (k <= 3)});
    end

    // Reset clears the error.
    drive(1, 0, 6'h00, 0, 0);
    drive(0, 0, 6'h00, 0, 0);
    chk("error_cleared", 3000, {3'b0, CTL_Error}, 4'h0);
    chk("idle_after_reset", 3001, {3'b0, CTL_Busy}, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
